split_arbiter_rr: RTL and testbench
===================================

Name: split_arbiter_rr

Overview:
- Parametrised successor of the fixed 12-master/6-slave bus controller.
- Arbitrates a shared serial bus among N_MASTERS masters grouped into N_PRIO priority groups, with round-robin selection inside each group.
- Tracks split transactions for N_SLAVES slaves and re-grants the bus to the originating master when a slave completes.
- Adds a grant-pickup timeout with an error pulse. Sits at the top-level bus between the master and slave ports.

Parameters:
- N_MASTERS, 12, number of masters; must be a multiple of N_PRIO.
- N_PRIO, 3, priority groups; group g = masters g*GS .. g*GS+GS-1, where GS = N_MASTERS/N_PRIO; group 0 is highest.
- N_SLAVES, 6, number of split-capable slaves.
- GRANT_TIMEOUT, 15, cycles allowed for a granted master to pick up the bus.
- MID_W, $clog2(N_MASTERS+1), master-id width; MID_NONE = all ones.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active high.
- m_reqs  in  N_MASTERS  level request per master.
- m_grants  out  N_MASTERS  registered one-hot grant; all zero = none.
- bus_util  in  1  1 = bus idle/released, 0 = bus driven by a master.
- slaves_in  in  N_SLAVES  split indicator; high while the slave holds a split.
- slaves_out  out  N_SLAVES  one-cycle resume acknowledge pulse.
- state  out  3  FSM state code.
- mid_current  out  MID_W  current owner id; MID_NONE if none.
- timeout_err  out  1  one-cycle pulse on a grant timeout.

Behaviour:
- Reset values: m_grants=0, slaves_out=0, timeout_err=0, state=IDLE, mid_current=MID_NONE. All slave entries FREE with mid MID_NONE; blocked mask=0; RR pointers=0; timeout counter=0. Reset wins over any concurrent event.
- State codes: IDLE=0, SPLIT_SAVE=1, SPLIT_WAIT=2, SEARCH=3, WAIT_FREE=4, GRANT=5, HOLD=6, ACK_SLAVE=7.
- Eligible request = m_reqs & ~blocked. Owner group = mid_current / GS.
- IDLE / HOLD selection (in this priority order):
  - Any slave DONE -> SEARCH (resume).
  - Else if an owner exists and no eligible request exists in a strictly higher group -> stay.
  - Else if any eligible request exists -> SEARCH.
  - In HOLD, bus_util=1 (owner released) -> mid_current=MID_NONE, grant cleared, back to IDLE.
- SEARCH (1 cycle):
  - Resume case: lowest-index DONE slave; target = its stored mid; resume flag set.
  - Otherwise: highest-priority group with an eligible request. Within that group, the first eligible master at or after the group's RR pointer, wrapping modulo GS.
  - Next state is WAIT_FREE.
- WAIT_FREE: m_grants forced to 0, which preempts any current owner. Stays until bus_util=1, then -> GRANT.
- GRANT:
  - Drives m_grants one-hot for the target; mid_current=target; the counter counts cycles.
  - bus_util=0 (pickup) -> RR pointer of that group = target+1 (wrapping), counter cleared, then ACK_SLAVE if resume, else HOLD.
  - Counter reaches GRANT_TIMEOUT with no pickup -> grant dropped, mid_current=MID_NONE, timeout_err pulses, RR pointer advances past the target, -> IDLE. A resume slave stays DONE and is retried.
- Split capture (HOLD only):
  - A FREE slave with slaves_in=1 -> SPLIT_SAVE. The lowest index wins; others are seen on later cycles.
  - SPLIT_SAVE: slave = BUSY, mid = mid_current, blocked[mid_current]=1, grant dropped -> SPLIT_WAIT.
  - SPLIT_WAIT: waits for bus_util=1, then mid_current=MID_NONE -> IDLE.
  - slaves_in=1 outside HOLD on a FREE slave is ignored.
- Completion: a BUSY slave with slaves_in=0 becomes DONE in any state (evaluated every cycle, all slaves in parallel).
- ACK_SLAVE (1 cycle): slaves_out[sid]=1 for exactly this cycle. Slave entry -> FREE / MID_NONE; blocked[target]=0 -> HOLD.
- A blocked master's request is ignored until its slave resumes it. A slave never gets a second entry while not FREE.

Test Plan:
- Reset at defaults, then m_reqs=12'h0F0 with bus_util=1 -> m_grants=12'h010 by state GRANT; bus_util=0 -> HOLD, mid_current=4. Release and keep the request -> next grant 12'h020 (round-robin).
- Owner mid 9 in HOLD; m_reqs[2] rises -> m_grants=0 in WAIT_FREE. Bus released -> m_grants=12'h004.
- Owner mid 5; slaves_in[3] rises -> blocked[5]=1, m_grants=0, state SPLIT_WAIT then IDLE. m_reqs[5] ignored until slaves_in[3] falls. Then mid 5 is re-granted, slaves_out[3] pulses exactly 1 cycle, blocked[5]=0.
- Grant to mid 0 with bus_util held 1 for 15 cycles -> timeout_err pulse, m_grants=0. With m_reqs=12'h003 held, the next grant goes to mid 1.
- Slaves 1 and 4 both DONE in the same cycle -> slave 1's master is resumed first, then slave 4's.
- rst asserted during GRANT -> next cycle m_grants=0, slaves_out=0, state=0, mid_current=MID_NONE.

Source files
------------

// File: rtl/split_arbiter_rr.sv
// Split-transaction bus arbiter: priority groups with round-robin inside each group,
// split/resume tracking per slave, and a grant-pickup timeout.
module split_arbiter_rr #(
    parameter int N_MASTERS     = 12,
    parameter int N_PRIO        = 3,
    parameter int N_SLAVES      = 6,
    parameter int GRANT_TIMEOUT = 15,
    parameter int MID_W         = $clog2(N_MASTERS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] m_reqs,
    output logic [N_MASTERS-1:0] m_grants,
    input  logic                 bus_util,
    input  logic [N_SLAVES-1:0]  slaves_in,
    output logic [N_SLAVES-1:0]  slaves_out,
    output logic [2:0]           state,
    output logic [MID_W-1:0]     mid_current,
    output logic                 timeout_err
);

    localparam int GS    = N_MASTERS / N_PRIO;
    localparam int PTR_W = (GS > 1) ? $clog2(GS) : 1;
    localparam int SID_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [MID_W-1:0] MID_NONE = '1;
    localparam logic [N_MASTERS-1:0] GRANT_ONE = {{(N_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SPLIT_SAVE = 3'd1,
        SPLIT_WAIT = 3'd2,
        SEARCH     = 3'd3,
        WAIT_FREE  = 3'd4,
        GRANT      = 3'd5,
        HOLD       = 3'd6,
        ACK_SLAVE  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } slave_st_t;

    state_t                 state_q, state_d;
    logic [MID_W-1:0]       mid_d, target_q, target_d;
    logic                   resume_q, resume_d;
    logic [SID_W-1:0]       resume_sid_q, resume_sid_d;
    logic [SID_W-1:0]       split_sid_q, split_sid_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    slave_st_t              slave_st_q  [N_SLAVES];
    slave_st_t              slave_st_d  [N_SLAVES];
    logic [MID_W-1:0]       slave_mid_q [N_SLAVES];
    logic [MID_W-1:0]       slave_mid_d [N_SLAVES];
    logic [N_MASTERS-1:0]   blocked_q, blocked_d;
    logic [PTR_W-1:0]       rr_ptr_q    [N_PRIO];
    logic [PTR_W-1:0]       rr_ptr_d    [N_PRIO];
    logic [N_MASTERS-1:0]   m_grants_d;
    logic [N_SLAVES-1:0]    slaves_out_d;
    logic                   timeout_err_d;

    logic [N_MASTERS-1:0]   eligible;
    logic                   any_elig, owner_valid, higher_elig;
    logic                   any_done, split_hit, sel_found;
    logic [SID_W-1:0]       done_sid, split_sel;
    logic [MID_W-1:0]       sel_mid;
    int                     owner_grp, sel_grp, tgt_grp, tgt_loc, idx;

    assign state = state_q;

    // Request decode: eligibility, preemption check, DONE/split scan, round-robin pick.
    always_comb begin
        eligible    = m_reqs & ~blocked_q;
        any_elig    = |eligible;
        owner_valid = (mid_current != MID_NONE);
        owner_grp   = owner_valid ? int'(mid_current) / GS : N_PRIO;
        higher_elig = 1'b0;
        any_done    = 1'b0;
        done_sid    = '0;
        split_hit   = 1'b0;
        split_sel   = '0;
        sel_found   = 1'b0;
        sel_grp     = 0;
        sel_mid     = MID_NONE;
        idx         = 0;
        tgt_grp     = int'(target_q) / GS;
        tgt_loc     = int'(target_q) % GS;

        for (int g = 0; g < N_PRIO; g++) begin
            if (g < owner_grp && |eligible[g*GS +: GS]) higher_elig = 1'b1;
        end
        for (int s = N_SLAVES - 1; s >= 0; s--) begin
            if (slave_st_q[s] == DONE) begin
                any_done = 1'b1;
                done_sid = SID_W'(s);
            end
            if (slave_st_q[s] == FREE && slaves_in[s]) begin
                split_hit = 1'b1;
                split_sel = SID_W'(s);
            end
        end
        for (int g = N_PRIO - 1; g >= 0; g--) begin
            if (|eligible[g*GS +: GS]) begin
                sel_found = 1'b1;
                sel_grp   = g;
            end
        end
        // Descending scan so the smallest offset from the pointer wins.
        for (int k = GS - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q[sel_grp]) + k) % GS;
            if (eligible[sel_grp*GS + idx]) sel_mid = MID_W'(sel_grp*GS + idx);
        end
    end

    always_comb begin
        state_d       = state_q;
        mid_d         = mid_current;
        target_d      = target_q;
        resume_d      = resume_q;
        resume_sid_d  = resume_sid_q;
        split_sid_d   = split_sid_q;
        cnt_d         = cnt_q;
        slave_st_d    = slave_st_q;
        slave_mid_d   = slave_mid_q;
        blocked_d     = blocked_q;
        rr_ptr_d      = rr_ptr_q;
        slaves_out_d  = '0;
        timeout_err_d = 1'b0;

        for (int s = 0; s < N_SLAVES; s++) begin
            if (slave_st_q[s] == BUSY && !slaves_in[s]) slave_st_d[s] = DONE;
        end

        case (state_q)
            IDLE: begin
                if (any_done)                        state_d = SEARCH;
                else if (owner_valid && !higher_elig) state_d = IDLE;
                else if (any_elig)                   state_d = SEARCH;
            end
            HOLD: begin
                // A split must be recorded before the owner's release is honoured.
                if (split_hit) begin
                    split_sid_d = split_sel;
                    state_d     = SPLIT_SAVE;
                end else if (bus_util) begin
                    mid_d   = MID_NONE;
                    state_d = IDLE;
                end else if (any_done || higher_elig) begin
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (any_done) begin
                    target_d     = slave_mid_q[done_sid];
                    resume_d     = 1'b1;
                    resume_sid_d = done_sid;
                    state_d      = WAIT_FREE;
                end else if (sel_found) begin
                    target_d = sel_mid;
                    resume_d = 1'b0;
                    state_d  = WAIT_FREE;
                end else begin
                    state_d = owner_valid ? HOLD : IDLE;
                end
            end
            WAIT_FREE: begin
                if (bus_util) begin
                    mid_d   = target_q;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!bus_util) begin
                    rr_ptr_d[tgt_grp] = PTR_W'((tgt_loc + 1) % GS);
                    cnt_d             = '0;
                    if (resume_q) begin
                        slaves_out_d[resume_sid_q] = 1'b1;
                        state_d                    = ACK_SLAVE;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (cnt_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
                    rr_ptr_d[tgt_grp] = PTR_W'((tgt_loc + 1) % GS);
                    cnt_d             = '0;
                    mid_d             = MID_NONE;
                    resume_d          = 1'b0;
                    timeout_err_d     = 1'b1;
                    state_d           = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK_SLAVE: begin
                slave_st_d[resume_sid_q]  = FREE;
                slave_mid_d[resume_sid_q] = MID_NONE;
                if (int'(target_q) < N_MASTERS) blocked_d[target_q] = 1'b0;
                resume_d = 1'b0;
                state_d  = HOLD;
            end
            SPLIT_SAVE: begin
                slave_st_d[split_sid_q]  = BUSY;
                slave_mid_d[split_sid_q] = mid_current;
                if (int'(mid_current) < N_MASTERS) blocked_d[mid_current] = 1'b1;
                state_d = SPLIT_WAIT;
            end
            SPLIT_WAIT: begin
                if (bus_util) begin
                    mid_d   = MID_NONE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The grant follows the owner except while waiting for the bus or a split release.
        m_grants_d = '0;
        if (mid_d != MID_NONE && (state_d == IDLE || state_d == SEARCH || state_d == GRANT ||
                                  state_d == HOLD || state_d == ACK_SLAVE || state_d == SPLIT_SAVE))
            m_grants_d = GRANT_ONE << mid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mid_current  <= MID_NONE;
            target_q     <= MID_NONE;
            resume_q     <= 1'b0;
            resume_sid_q <= '0;
            split_sid_q  <= '0;
            cnt_q        <= '0;
            slave_st_q   <= '{default: FREE};
            slave_mid_q  <= '{default: MID_NONE};
            blocked_q    <= '0;
            rr_ptr_q     <= '{default: '0};
            m_grants     <= '0;
            slaves_out   <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mid_current  <= mid_d;
            target_q     <= target_d;
            resume_q     <= resume_d;
            resume_sid_q <= resume_sid_d;
            split_sid_q  <= split_sid_d;
            cnt_q        <= cnt_d;
            slave_st_q   <= slave_st_d;
            slave_mid_q  <= slave_mid_d;
            blocked_q    <= blocked_d;
            rr_ptr_q     <= rr_ptr_d;
            m_grants     <= m_grants_d;
            slaves_out   <= slaves_out_d;
            timeout_err  <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_split_arbiter_rr.sv
// Directed bench for split_arbiter_rr: round-robin, preemption, split/resume,
// grant timeout, simultaneous completions and reset during a grant.
module tb_split_arbiter_rr;

    localparam logic [2:0] S_IDLE = 3'd0, S_SPLIT_SAVE = 3'd1, S_SPLIT_WAIT = 3'd2,
                           S_SEARCH = 3'd3, S_WAIT_FREE = 3'd4, S_GRANT = 3'd5,
                           S_HOLD = 3'd6, S_ACK = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] m_reqs;
    logic [11:0] m_grants;
    logic        bus_util;
    logic [5:0]  slaves_in;
    logic [5:0]  slaves_out;
    logic [2:0]  state;
    logic [3:0]  mid_current;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    split_arbiter_rr dut (
        .clk(clk), .rst(rst), .m_reqs(m_reqs), .m_grants(m_grants),
        .bus_util(bus_util), .slaves_in(slaves_in), .slaves_out(slaves_out),
        .state(state), .mid_current(mid_current), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [11:0] reqs, input logic util, input logic [5:0] sin);
        m_reqs    = reqs;
        bus_util  = util;
        slaves_in = sin;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitState(input string tag, input logic [2:0] s, input int max_cycles);
        int n = 0;
        while (state !== s && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(state), 32'(s));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(12'h000, 1'b1, 6'h00);
        tick(); tick();
        checkOutput("rst_state", 32'(state), 32'(S_IDLE));
        checkOutput("rst_grants", 32'(m_grants), 32'h0);
        checkOutput("rst_mid", 32'(mid_current), 32'hF);
        checkOutput("rst_sout", 32'(slaves_out), 32'h0);
        checkOutput("rst_terr", 32'(timeout_err), 32'h0);
        rst = 1'b0;
        tick();

        // Round-robin inside group 1
        applyStimulus(12'h0F0, 1'b1, 6'h00);
        waitState("s1_grant", S_GRANT, 12);
        checkOutput("s1_grants", 32'(m_grants), 32'h010);
        applyStimulus(12'h0F0, 1'b0, 6'h00); tick();
        checkOutput("s1_hold", 32'(state), 32'(S_HOLD));
        checkOutput("s1_mid", 32'(mid_current), 32'd4);
        applyStimulus(12'h0F0, 1'b1, 6'h00); tick();
        checkOutput("s1_release", 32'(mid_current), 32'hF);
        waitState("s1_grant2", S_GRANT, 12);
        checkOutput("s1_rr_grants", 32'(m_grants), 32'h020);
        applyStimulus(12'h0F0, 1'b0, 6'h00); tick();
        applyStimulus(12'h200, 1'b1, 6'h00); tick();

        // Preemption of group-2 owner by a group-0 request
        waitState("s2_grant9", S_GRANT, 12);
        checkOutput("s2_mid9", 32'(mid_current), 32'd9);
        applyStimulus(12'h200, 1'b0, 6'h00); tick();
        checkOutput("s2_hold", 32'(state), 32'(S_HOLD));
        applyStimulus(12'h204, 1'b0, 6'h00); tick(); tick();
        checkOutput("s2_waitfree", 32'(state), 32'(S_WAIT_FREE));
        checkOutput("s2_preempt_grants", 32'(m_grants), 32'h0);
        tick();
        checkOutput("s2_still_wait", 32'(state), 32'(S_WAIT_FREE));
        applyStimulus(12'h204, 1'b1, 6'h00); tick();
        checkOutput("s2_grants", 32'(m_grants), 32'h004);
        checkOutput("s2_mid2", 32'(mid_current), 32'd2);
        applyStimulus(12'h000, 1'b0, 6'h00); tick();
        applyStimulus(12'h000, 1'b1, 6'h00); tick();

        // Split on slave 3 by master 5, then resume
        applyStimulus(12'h020, 1'b1, 6'h00);
        waitState("s3_grant", S_GRANT, 12);
        checkOutput("s3_mid5", 32'(mid_current), 32'd5);
        applyStimulus(12'h020, 1'b0, 6'h00); tick();
        applyStimulus(12'h020, 1'b0, 6'h08); tick();
        checkOutput("s3_save", 32'(state), 32'(S_SPLIT_SAVE));
        tick();
        checkOutput("s3_wait", 32'(state), 32'(S_SPLIT_WAIT));
        checkOutput("s3_wait_grants", 32'(m_grants), 32'h0);
        applyStimulus(12'h020, 1'b1, 6'h08); tick();
        checkOutput("s3_idle_mid", 32'(mid_current), 32'hF);
        tick(); tick(); tick();
        checkOutput("s3_blocked_state", 32'(state), 32'(S_IDLE));
        checkOutput("s3_blocked_grants", 32'(m_grants), 32'h0);
        applyStimulus(12'h020, 1'b1, 6'h00);
        waitState("s3_resume", S_GRANT, 12);
        checkOutput("s3_resume_grants", 32'(m_grants), 32'h020);
        checkOutput("s3_no_early_ack", 32'(slaves_out), 32'h0);
        applyStimulus(12'h020, 1'b0, 6'h00); tick();
        checkOutput("s3_ack_state", 32'(state), 32'(S_ACK));
        checkOutput("s3_ack_pulse", 32'(slaves_out), 32'h08);
        tick();
        checkOutput("s3_ack_end", 32'(slaves_out), 32'h00);
        checkOutput("s3_hold", 32'(state), 32'(S_HOLD));
        applyStimulus(12'h020, 1'b1, 6'h00); tick();
        waitState("s3_unblocked", S_GRANT, 12);
        checkOutput("s3_unblocked_grants", 32'(m_grants), 32'h020);
        applyStimulus(12'h000, 1'b0, 6'h00); tick();
        applyStimulus(12'h000, 1'b1, 6'h00); tick();

        // Grant timeout on master 0, then round-robin moves to master 1
        applyStimulus(12'h003, 1'b1, 6'h00);
        waitState("s4_grant", S_GRANT, 12);
        checkOutput("s4_grants", 32'(m_grants), 32'h001);
        repeat (14) tick();
        checkOutput("s4_no_timeout_yet", 32'(timeout_err), 32'h0);
        checkOutput("s4_still_grant", 32'(state), 32'(S_GRANT));
        tick();
        checkOutput("s4_timeout", 32'(timeout_err), 32'h1);
        checkOutput("s4_to_grants", 32'(m_grants), 32'h0);
        checkOutput("s4_to_mid", 32'(mid_current), 32'hF);
        tick();
        checkOutput("s4_pulse_end", 32'(timeout_err), 32'h0);
        waitState("s4_regrant", S_GRANT, 12);
        checkOutput("s4_next_grants", 32'(m_grants), 32'h002);
        applyStimulus(12'h000, 1'b0, 6'h00); tick();
        applyStimulus(12'h000, 1'b1, 6'h00); tick();

        // Slaves 1 and 4 complete together: slave 1 resumed first
        applyStimulus(12'h001, 1'b1, 6'h00);
        waitState("s5_grant0", S_GRANT, 12);
        checkOutput("s5_grants0", 32'(m_grants), 32'h001);
        applyStimulus(12'h001, 1'b0, 6'h00); tick();
        applyStimulus(12'h001, 1'b0, 6'h02); tick(); tick();
        applyStimulus(12'h001, 1'b1, 6'h02); tick();
        applyStimulus(12'h800, 1'b1, 6'h02);
        waitState("s5_grant11", S_GRANT, 12);
        checkOutput("s5_grants11", 32'(m_grants), 32'h800);
        applyStimulus(12'h800, 1'b0, 6'h02); tick();
        applyStimulus(12'h800, 1'b0, 6'h12); tick();
        checkOutput("s5_save4", 32'(state), 32'(S_SPLIT_SAVE));
        tick();
        applyStimulus(12'h000, 1'b1, 6'h12); tick();
        applyStimulus(12'h000, 1'b1, 6'h00);
        waitState("s5_resume1", S_GRANT, 12);
        checkOutput("s5_resume1_grants", 32'(m_grants), 32'h001);
        applyStimulus(12'h000, 1'b0, 6'h00); tick();
        checkOutput("s5_ack1", 32'(slaves_out), 32'h02);
        tick();
        checkOutput("s5_hold", 32'(state), 32'(S_HOLD));
        tick();
        checkOutput("s5_second_search", 32'(state), 32'(S_SEARCH));
        applyStimulus(12'h000, 1'b1, 6'h00);
        waitState("s5_resume4", S_GRANT, 12);
        checkOutput("s5_resume4_grants", 32'(m_grants), 32'h800);
        applyStimulus(12'h000, 1'b0, 6'h00); tick();
        checkOutput("s5_ack4", 32'(slaves_out), 32'h10);
        tick();
        applyStimulus(12'h000, 1'b1, 6'h00); tick();

        // Reset while a grant is pending
        applyStimulus(12'h004, 1'b1, 6'h00);
        waitState("s6_grant", S_GRANT, 12);
        checkOutput("s6_grants", 32'(m_grants), 32'h004);
        rst = 1'b1;
        tick();
        checkOutput("s6_rst_grants", 32'(m_grants), 32'h0);
        checkOutput("s6_rst_sout", 32'(slaves_out), 32'h0);
        checkOutput("s6_rst_state", 32'(state), 32'(S_IDLE));
        checkOutput("s6_rst_mid", 32'(mid_current), 32'hF);
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
